// File: rtl/dac_link_pkg.sv
// Shared definitions for the 4-wire DAC serial link (cs, sclk, sdi, ldac).
// Holds the frame field positions, the nominal frame length and the
// receive FSM state type used by dac_spi_receiver.
package dac_link_pkg;

    // Frame field positions (frame is shifted in MSB first)
    localparam int CH_BIT     = 15;  // 0 = channel A, 1 = channel B
    localparam int BUF_BIT    = 14;  // reference buffer enable
    localparam int GA_BIT     = 13;  // gain select
    localparam int SHDN_BIT   = 12;  // 1 = channel active, data loaded

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } rx_state_t;

endpackage

// File: rtl/pin_sync_edge.sv
// Synchroniser plus history flop for one asynchronous pin.
// Ports:
//   clk_i   - sampling clock
//   rst_i   - asynchronous active-high reset (all flops go to RESET_VAL)
//   pin_i   - asynchronous pin
//   level_o - synchronised level (last synchroniser stage)
//   rise_o  - one-cycle strobe, synchronised level went 0 -> 1
//   fall_o  - one-cycle strobe, synchronised level went 1 -> 0
module pin_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/dac_spi_receiver.sv
// Receive side of the 4-wire DAC serial link. Oversamples the link pins on
// clk100, deserialises frames into per-channel input registers and moves
// them to the output registers on ldac.
// Ports:
//   clk100, rst             - system clock, asynchronous active-high reset
//   cs, sclk, sdi, ldac     - asynchronous link pins (cs/ldac active low)
//   frame_word              - last valid frame
//   frame_valid, frame_err  - one-cycle pulses per accepted / bad-length frame
//   dac_a, dac_b            - channel output registers
//   dac_update              - one-cycle pulse when dac_a/dac_b are loaded
//   active_a, active_b      - channel SHDN (enable) flags
module dac_spi_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = dac_link_pkg::FRAME_BITS,
    parameter int DATA_W      = 12
) (
    input  logic                  clk100,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  sclk,
    input  logic                  sdi,
    input  logic                  ldac,
    output logic [FRAME_BITS-1:0] frame_word,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [DATA_W-1:0]     dac_a,
    output logic [DATA_W-1:0]     dac_b,
    output logic                  dac_update,
    output logic                  active_a,
    output logic                  active_b
);

    import dac_link_pkg::*;

    // Counter runs to FRAME_BITS+1 so that overlong frames are still detected
    localparam int              CNT_W   = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_OK  = CNT_W'(FRAME_BITS);

    // Pin synchronisers
    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ldac_lvl, ldac_rise, ldac_fall;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic sdi_s;

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
        .clk_i(clk100), .rst_i(rst), .pin_i(cs),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .clk_i(clk100), .rst_i(rst), .pin_i(sclk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ldac (
        .clk_i(clk100), .rst_i(rst), .pin_i(ldac),
        .level_o(ldac_lvl), .rise_o(ldac_rise), .fall_o(ldac_fall)
    );

    // Same depth as the sclk chain, so sdi_s is the data that was on the
    // pin when the decoded sclk rise happened.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            sdi_sync_q <= '0;
        end else begin
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
        end
    end

    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

    // Registers
    rx_state_t             state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d, shreg_n;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_n;
    logic [FRAME_BITS-1:0] frame_word_q, frame_word_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [DATA_W-1:0]     in_a_q, in_a_d, in_b_q, in_b_d;
    logic [DATA_W-1:0]     dac_a_q, dac_a_d, dac_b_q, dac_b_d;
    logic                  dac_update_q, dac_update_d;
    logic                  active_a_q, active_a_d, active_b_q, active_b_d;

    // Configuration bits travel in frame_word only
    logic [1:0] unused_sig;
    assign unused_sig = {sclk_lvl ^ sclk_fall ^ ldac_rise,
                         frame_word_q[BUF_BIT] ^ frame_word_q[GA_BIT]};

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        frame_word_d  = frame_word_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        in_a_d        = in_a_q;
        in_b_d        = in_b_q;
        dac_a_d       = dac_a_q;
        dac_b_d       = dac_b_q;
        dac_update_d  = 1'b0;
        active_a_d    = active_a_q;
        active_b_d    = active_b_q;

        // Shift result for this cycle; used before decode so that an sclk
        // rise coinciding with the cs rise still counts towards the frame.
        shreg_n = shreg_q;
        cnt_n   = cnt_q;
        if (sclk_rise) begin
            shreg_n = {shreg_q[FRAME_BITS-2:0], sdi_s};
            cnt_n   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end

        case (state_q)
            WAIT_IDLE: begin
                // The synchroniser chains come out of reset at their idle
                // values, not the real pin levels. cnt_q times the flush so
                // a cs held low through reset cannot look like idle-then-fall.
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (cs_lvl && (cnt_q >= CNT_W'(SYNC_STAGES))) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            end

            SHIFT: begin
                shreg_d = shreg_n;
                cnt_d   = cnt_n;
                if (cs_rise) begin
                    state_d = IDLE;
                    if (cnt_n == CNT_OK) begin
                        frame_valid_d = 1'b1;
                        frame_word_d  = shreg_n;
                        if (!shreg_n[CH_BIT]) begin
                            active_a_d = shreg_n[SHDN_BIT];
                            if (shreg_n[SHDN_BIT]) begin
                                in_a_d = shreg_n[DATA_W-1:0];
                            end
                        end else begin
                            active_b_d = shreg_n[SHDN_BIT];
                            if (shreg_n[SHDN_BIT]) begin
                                in_b_d = shreg_n[DATA_W-1:0];
                            end
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            default: state_d = WAIT_IDLE;
        endcase

        // Latch from the post-decode input registers: a frame accepted with
        // ldac low (or on the same cycle as an ldac fall) goes straight out.
        if (ldac_fall || (frame_valid_d && !ldac_lvl)) begin
            dac_a_d      = in_a_d;
            dac_b_d      = in_b_d;
            dac_update_d = 1'b1;
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state_q       <= WAIT_IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            frame_word_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            in_a_q        <= '0;
            in_b_q        <= '0;
            dac_a_q       <= '0;
            dac_b_q       <= '0;
            dac_update_q  <= 1'b0;
            active_a_q    <= 1'b0;
            active_b_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            frame_word_q  <= frame_word_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            in_a_q        <= in_a_d;
            in_b_q        <= in_b_d;
            dac_a_q       <= dac_a_d;
            dac_b_q       <= dac_b_d;
            dac_update_q  <= dac_update_d;
            active_a_q    <= active_a_d;
            active_b_q    <= active_b_d;
        end
    end

    assign frame_word  = frame_word_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign dac_a       = dac_a_q;
    assign dac_b       = dac_b_q;
    assign dac_update  = dac_update_q;
    assign active_a    = active_a_q;
    assign active_b    = active_b_q;

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Bench for dac_spi_receiver: bit-banged link frames (directed and random)
// compared against a frame-level reference model.
module tb_dac_spi_receiver;

    localparam int SYNC_STAGES = 2;
    localparam int FRAME_BITS  = 16;
    localparam int DATA_W      = 12;
    localparam int HALF        = 250;   // 2 MHz sclk

    logic clk100 = 1'b0;
    logic rst    = 1'b1;
    logic cs     = 1'b1;
    logic sclk   = 1'b0;
    logic sdi    = 1'b0;
    logic ldac   = 1'b1;

    logic [FRAME_BITS-1:0] frame_word;
    logic                  frame_valid, frame_err, dac_update;
    logic [DATA_W-1:0]     dac_a, dac_b;
    logic                  active_a, active_b;

    always #5 clk100 = ~clk100;

    dac_spi_receiver #(
        .SYNC_STAGES(SYNC_STAGES), .FRAME_BITS(FRAME_BITS), .DATA_W(DATA_W)
    ) dut (
        .clk100(clk100), .rst(rst), .cs(cs), .sclk(sclk), .sdi(sdi), .ldac(ldac),
        .frame_word(frame_word), .frame_valid(frame_valid), .frame_err(frame_err),
        .dac_a(dac_a), .dac_b(dac_b), .dac_update(dac_update),
        .active_a(active_a), .active_b(active_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counters observed on the DUT
    int seen_valid = 0, seen_err = 0, seen_upd = 0, seen_coinc = 0;

    always @(negedge clk100) begin
        if (!rst) begin
            if (frame_valid === 1'b1) seen_valid++;
            if (frame_err === 1'b1) seen_err++;
            if (dac_update === 1'b1) seen_upd++;
            if (dac_update === 1'b1 && frame_valid === 1'b1) seen_coinc++;
        end
    end

    // Reference model: link behaviour at frame/strobe granularity
    logic [11:0] m_in_a, m_in_b, m_dac_a, m_dac_b;
    logic [15:0] m_fw;
    logic        m_act_a, m_act_b;
    int e_valid = 0, e_err = 0, e_upd = 0, e_coinc = 0;

    task automatic model_reset();
        m_in_a = '0; m_in_b = '0; m_dac_a = '0; m_dac_b = '0;
        m_fw = '0; m_act_a = 1'b0; m_act_b = 1'b0;
    endtask

    task automatic model_latch();
        m_dac_a = m_in_a;
        m_dac_b = m_in_b;
        e_upd++;
    endtask

    task automatic model_frame(input logic [31:0] w, input int n);
        logic       ch, shdn;
        logic [11:0] data;
        if (n != 16) begin
            e_err++;
        end else begin
            e_valid++;
            m_fw = w[15:0];
            ch   = (w >> 15) & 1;
            shdn = (w >> 12) & 1;
            data = w[11:0];
            if (ch == 1'b0) begin
                m_act_a = shdn;
                if (shdn) m_in_a = data;
            end else begin
                m_act_b = shdn;
                if (shdn) m_in_b = data;
            end
            if (ldac == 1'b0) begin
                model_latch();
                e_coinc++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".frame_word"}, frame_word, m_fw);
        chk({tag, ".dac_a"}, dac_a, m_dac_a);
        chk({tag, ".dac_b"}, dac_b, m_dac_b);
        chk({tag, ".active_a"}, active_a, m_act_a);
        chk({tag, ".active_b"}, active_b, m_act_b);
        chk({tag, ".n_valid"}, seen_valid, e_valid);
        chk({tag, ".n_err"}, seen_err, e_err);
        chk({tag, ".n_update"}, seen_upd, e_upd);
        chk({tag, ".n_upd_with_valid"}, seen_coinc, e_coinc);
    endtask

    // n bits of w, MSB first; fuse raises cs together with the last sclk rise
    task automatic shift_bits(input logic [31:0] w, input int n, input bit fuse);
        for (int i = 0; i < n; i++) begin
            sdi = w[n-1-i];
            #HALF;
            sclk = 1'b1;
            if (fuse && i == n - 1) cs = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input string tag, input logic [31:0] w, input int n, input bit fuse);
        cs = 1'b0;
        #HALF;
        shift_bits(w, n, fuse);
        if (!fuse) begin
            #HALF;
            cs = 1'b1;
        end
        #600;
        model_frame(w, n);
        check_all(tag);
    endtask

    task automatic ldac_pulse(input string tag);
        ldac = 1'b0;
        #300;
        ldac = 1'b1;
        #300;
        model_latch();
        check_all(tag);
    endtask

    task automatic set_ldac(input logic v);
        ldac = v;
        #300;
        if (v == 1'b0) model_latch();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int n;
        bit fuse, hold;

        model_reset();
        #100;
        rst = 1'b0;
        #200;
        check_all("reset");

        // Frame to A with ldac high, latch 1 us later
        send_frame("f3ABC", 32'h3ABC, 16, 1'b0);
        #1000;
        ldac_pulse("ldac_after_3ABC");

        // ldac held low: channel B goes straight through
        set_ldac(1'b0);
        send_frame("fB123_ldac_low", 32'hB123, 16, 1'b0);
        set_ldac(1'b1);

        // Bad frame lengths
        send_frame("short15", 32'h7FFF, 15, 1'b0);
        send_frame("long17", 32'h1FFFF, 17, 1'b0);

        // SHDN=0 frame clears active but keeps data
        send_frame("f3555", 32'h3555, 16, 1'b0);
        send_frame("f2AAA", 32'h2AAA, 16, 1'b0);
        ldac_pulse("ldac_after_2AAA");

        // Controller-style back-to-back sequence
        send_frame("ctl_a", 32'h3000 | 32'h7FF, 16, 1'b0);
        send_frame("ctl_b", 32'hB000 | 32'h001, 16, 1'b0);
        ldac_pulse("ctl_ldac");

        // cs rise together with the final sclk rise
        send_frame("fused_edge", 32'h3246, 16, 1'b1);

        // Latency: frame_valid on the 3rd clk100 rise after cs rises
        cs = 1'b0;
        #HALF;
        shift_bits(32'h3468, 16, 1'b0);
        #HALF;
        cs = 1'b1;
        @(posedge clk100);
        @(posedge clk100);
        #1;
        chk("latency.early", frame_valid, 1'b0);
        @(posedge clk100);
        #1;
        chk("latency.edge", frame_valid, 1'b1);
        #4;
        #600;
        model_frame(32'h3468, 16);
        check_all("latency");

        // ldac pulse mid-frame moves the pre-frame input values
        cs = 1'b0;
        #HALF;
        shift_bits(32'hB7, 8, 1'b0);
        ldac = 1'b0;
        #300;
        ldac = 1'b1;
        #300;
        model_latch();
        shift_bits(32'h77, 8, 1'b0);
        #HALF;
        cs = 1'b1;
        #600;
        model_frame(32'hB777, 16);
        check_all("ldac_mid_frame");

        // Reset in the middle of a frame, cs still low at release
        cs = 1'b0;
        #HALF;
        shift_bits(32'h3F, 8, 1'b0);
        rst = 1'b1;
        #50;
        model_reset();
        rst = 1'b0;
        shift_bits(32'hFF, 8, 1'b0);
        #HALF;
        cs = 1'b1;
        #600;
        check_all("rst_mid_frame");
        send_frame("after_rst", 32'h3123, 16, 1'b0);
        ldac_pulse("after_rst_ldac");

        // Random frames, lengths, ldac modes and fused edges
        for (int it = 0; it < 20; it++) begin
            w = $urandom;
            case ($urandom_range(0, 9))
                0:       n = 15;
                1:       n = 17;
                default: n = 16;
            endcase
            w = w & ((32'h1 << n) - 1);
            fuse = ($urandom_range(0, 3) == 0);
            hold = ($urandom_range(0, 3) == 0);
            if (hold) set_ldac(1'b0);
            send_frame($sformatf("rnd%0d", it), w, n, fuse);
            if (hold) set_ldac(1'b1);
            if ($urandom_range(0, 2) == 0) ldac_pulse($sformatf("rnd%0d_ldac", it));
        end

        #500;
        check_all("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_spi_receiver.md
Name: dac_spi_receiver

Overview:
Receive-side model of the team's 4-wire DAC serial link (cs, sclk, sdi, ldac). It deserialises 16-bit frames into per-channel input registers and transfers them to output registers on ldac. The block is synthesisable and is used in two places: as a loopback checker on the FPGA and as the responder in DAC_Controller benches. All link pins are asynchronous to clk100, and the block oversamples them.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each pin synchroniser (minimum 2)
FRAME_BITS, 16, required bit count per valid frame
DATA_W, 12, sample width; the data field is frame[DATA_W-1:0]

Ports:
clk100  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
cs  in  1  link chip select, active low
sclk  in  1  link serial clock; sdi is sampled on its rising edge
sdi  in  1  link serial data, MSB first
ldac  in  1  link latch strobe, active low
frame_word  out  16  last valid frame
frame_valid  out  1  one-cycle pulse when a valid frame is accepted
frame_err  out  1  one-cycle pulse when a frame has the wrong bit count
dac_a  out  DATA_W  channel A output register
dac_b  out  DATA_W  channel B output register
dac_update  out  1  one-cycle pulse when the output registers are loaded
active_a  out  1  channel A enabled (SHDN bit)
active_b  out  1  channel B enabled (SHDN bit)

Behaviour:
- Reset clears every output to 0 and clears the internal input registers in_a/in_b.
- Reset values of the synchroniser flops: cs and ldac chains = 1, sclk chain = 0.
- Each pin passes through SYNC_STAGES flops, then one history flop. Edges are decoded from the last synchroniser stage against the history flop.
- All outputs are registered. A pin edge therefore reaches an output pulse on the (SYNC_STAGES+1)th clk100 rising edge after the first edge that samples the new pin level.
- Frame FSM states: WAIT_IDLE, IDLE, SHIFT.
  - Reset enters WAIT_IDLE.
  - WAIT_IDLE -> IDLE once synchronised cs = 1. A frame already in flight at reset release is therefore ignored silently.
  - IDLE -> SHIFT on a cs falling edge. The transition clears the shift register and the bit counter.
  - SHIFT: each sclk rising edge shifts sdi into the LSB and increments the counter. The counter saturates at FRAME_BITS+1.
  - SHIFT -> IDLE on a cs rising edge. Decode: counter == FRAME_BITS gives frame_valid; any other count gives frame_err, and no register changes.
  - sclk edges while cs is high are ignored.
- Frame decode, for valid frames only:
  - bit15 selects the channel: 0 = A, 1 = B.
  - bit14 is BUF and bit13 is GA. Both are captured in frame_word only.
  - bit12 is SHDN. When SHDN = 1: active_x <= 1 and in_x <= frame[11:0].
  - When SHDN = 0: active_x <= 0 and in_x is unchanged.
  - frame_word is updated on every valid frame.
- Latch rule:
  - An ldac falling edge copies in_a -> dac_a and in_b -> dac_b, and pulses dac_update.
  - If synchronised ldac = 0 in the cycle a valid frame is accepted, the new in_x value is copied to dac_x in that same cycle. dac_update pulses coincident with frame_valid.
  - An ldac falling edge during SHIFT transfers the pre-frame in_a/in_b values.
- Simultaneous events:
  - If an ldac falling edge and a valid-frame decode land in the same cycle, the output uses the new in_x value, and dac_update fires once.
  - If cs rise and sclk rise are detected in the same cycle, the sclk bit is counted first and the frame is then decoded.
- rst asserted mid-frame aborts the frame with no pulse. After release the block waits for cs high before arming.

Decomposition:
- Package dac_link_pkg holds:
  - the frame bit positions: CH_BIT = 15, BUF_BIT = 14, GA_BIT = 13, SHDN_BIT = 12;
  - a FRAME_BITS constant;
  - the rx_state_t enum (WAIT_IDLE, IDLE, SHIFT).
- One sub-module: pin_sync_edge. It provides one synchroniser plus history flop with parameters SYNC_STAGES and RESET_VAL, and outputs level, rise and fall. It is instantiated for cs, sclk and ldac. sdi uses a plain synchroniser whose depth matches, so it stays aligned with sclk.

Test Plan:
- Frame 0x3ABC with ldac high, then an ldac low pulse 1 µs later -> frame_valid, frame_word = 0x3ABC, active_a = 1, dac_a stays 0 until the ldac fall; then dac_a = 0xABC, dac_update pulses once, dac_b = 0.
- ldac held low, frame 0xB123 -> dac_b = 0x123, with dac_update in the same cycle as frame_valid; dac_a unchanged.
- 15-bit frame, then a 17-bit frame -> two frame_err pulses, no frame_valid, and dac_a, dac_b, frame_word and active flags unchanged.
- Frame 0x3555, then frame 0x2AAA, then an ldac pulse -> active_a goes 1 then 0, and dac_a = 0x555 (the SHDN = 0 data is ignored).
- Back-to-back DAC_Controller-style sequence (0x3000|r1, 0xB000|r2, ldac pulse) at 2 MHz sclk, with r1 = 0x7FF and r2 = 0x001 -> dac_a = 0x7FF, dac_b = 0x001, exactly one dac_update per ldac.
- rst pulse at bit 8 of frame 0x3FFF, with cs still low at release -> no pulses and all outputs 0. The next full frame 0x3123 is accepted normally (dac_a = 0x123 after ldac).
